// File: rtl/param_shift_pkg.sv
// Shared definitions for the shift-register control slice: state encodings,
// default data width and the shift-count width derivation.
package param_shift_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A count of 0..width inclusive needs one more code than width itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/param_shift_ctrl_shift_down_counter.sv
// Loadable down-counter for the shift phase; values above MAX clamp to MAX
// when loaded so the register never sees more shifts than it has bits.
module shift_down_counter #(
    parameter int CNT_W = 4,
    parameter int MAX   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic             dec_en,
    input  logic             clr,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             is_one
);

    localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(MAX);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (clr) begin
            value <= '0;
        end else if (load_en) begin
            value <= (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (dec_en && value != '0) begin
            value <= value - ONE;
        end
    end

    assign is_one = (value == ONE);

endmodule

// File: rtl/param_shift_ctrl.sv
// Sequences load -> shift x N -> done into the parameterised shift register
// for each accepted {word, count} request; abort cuts straight to done.
module param_shift_ctrl
    import param_shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] word_in,
    input  logic [CNT_W-1:0] n_shifts,
    input  logic             abort,
    output logic             load,
    output logic             shift,
    output logic             done,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             finish
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] count;
    logic             count_is_one;
    logic             accept;

    // start_ready is itself a register, so nothing is accepted on the first
    // edge after reset release even if start_valid is already high.
    assign accept = (state == ST_IDLE) && start_ready && start_valid;

    shift_down_counter #(
        .CNT_W (CNT_W),
        .MAX   (WIDTH)
    ) u_counter (
        .clk      (clk),
        .reset    (reset),
        .load_en  (accept),
        .dec_en   (state == ST_SHIFT),
        .clr      (state == ST_DONE),
        .load_val (n_shifts),
        .value    (count),
        .is_one   (count_is_one)
    );

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = (abort || count == '0) ? ST_DONE : ST_SHIFT;
            ST_SHIFT: if (abort || count_is_one) state_nxt = ST_DONE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they are glitch-free and aligned with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            start_ready <= 1'b0;
            load        <= 1'b0;
            shift       <= 1'b0;
            done        <= 1'b0;
            finish      <= 1'b0;
            busy        <= 1'b0;
            data_in     <= '0;
        end else begin
            state       <= state_nxt;
            start_ready <= (state_nxt == ST_IDLE);
            load        <= (state_nxt == ST_LOAD);
            shift       <= (state_nxt == ST_SHIFT);
            done        <= (state_nxt == ST_DONE);
            finish      <= (state_nxt == ST_DONE);
            busy        <= (state_nxt != ST_IDLE);
            if (accept) begin
                data_in <= word_in;
            end
        end
    end

endmodule

// File: tb/tb_param_shift_ctrl.sv
// Directed bench for param_shift_ctrl: a vector table of complete transfers
// plus hand-written reset, idle-abort, back-to-back and mid-transfer sequences.
module tb_param_shift_ctrl;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] word_in;
    logic [CNT_W-1:0] n_shifts;
    logic             abort;
    logic             load;
    logic             shift;
    logic             done;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             finish;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0] word;
        logic [3:0] n;
        int         abort_at;   // -1 none, 0 in LOAD, k in k-th shift cycle
        int         exp_shifts;
        int         exp_ready;  // cycles after accept until start_ready
    } vec_t;

    vec_t vecs [9];

    param_shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .word_in     (word_in),
        .n_shifts    (n_shifts),
        .abort       (abort),
        .load        (load),
        .shift       (shift),
        .done        (done),
        .data_in     (data_in),
        .busy        (busy),
        .finish      (finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int waited = 0;
        while (start_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " ready_timeout"}, 32'(start_ready), 32'd1);
    endtask

    task automatic run_transfer(input logic [7:0] w, input logic [3:0] n, input int ab,
                                input int es, input int er, input string tag);
        int shifts = 0, loads = 0, dones = 0, fins = 0;
        int load_at = -1, done_at = -1, ready_at = -1;
        int bad_data = 0, bad_excl = 0, bad_busy = 0, bad_fin = 0;
        wait_ready(tag);
        word_in     = w;
        n_shifts    = n;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (start_ready === 1'b1) begin
                ready_at = cyc;
                break;
            end
            loads  += int'(load);
            shifts += int'(shift);
            dones  += int'(done);
            fins   += int'(finish);
            if (load)  load_at = cyc;
            if (done)  done_at = cyc;
            if (data_in !== w) bad_data++;
            if (int'(load) + int'(shift) + int'(done) > 1) bad_excl++;
            if (busy !== 1'b1) bad_busy++;
            if (finish !== done) bad_fin++;
            abort = (ab == 0 && load) || (ab > 0 && shift && shifts == ab);
            @(negedge clk);
        end
        abort = 1'b0;
        check({tag, " load_at"},    32'(load_at),  32'd0);
        check({tag, " loads"},      32'(loads),    32'd1);
        check({tag, " shifts"},     32'(shifts),   32'(es));
        check({tag, " dones"},      32'(dones),    32'd1);
        check({tag, " finishes"},   32'(fins),     32'd1);
        check({tag, " done_at"},    32'(done_at),  32'(es + 1));
        check({tag, " ready_at"},   32'(ready_at), 32'(er));
        check({tag, " data_hold"},  32'(bad_data), 32'd0);
        check({tag, " exclusive"},  32'(bad_excl), 32'd0);
        check({tag, " busy"},       32'(bad_busy), 32'd0);
        check({tag, " finish_eq"},  32'(bad_fin),  32'd0);
    endtask

    initial begin
        logic [7:0] d   [6];
        logic       ld  [6];
        logic       rdy [6];
        int         seen;

        vecs[0] = '{8'h01, 4'd3,  -1, 3, 5};
        vecs[1] = '{8'hFF, 4'd0,  -1, 0, 2};
        vecs[2] = '{8'h5A, 4'd15, -1, 8, 10};
        vecs[3] = '{8'hC3, 4'd8,   2, 2, 4};
        vecs[4] = '{8'h81, 4'd8,  -1, 8, 10};
        vecs[5] = '{8'hF0, 4'd1,  -1, 1, 3};
        vecs[6] = '{8'h3C, 4'd5,   0, 0, 2};
        vecs[7] = '{8'h96, 4'd8,   8, 8, 10};
        vecs[8] = '{8'h42, 4'd9,  -1, 8, 10};

        // Reset with inputs active: everything must stay 0.
        reset       = 1'b0;
        start_valid = 1'b1;
        word_in     = 8'hFF;
        n_shifts    = 4'd3;
        abort       = 1'b1;
        repeat (3) @(negedge clk);
        check("reset outputs", {start_ready, load, shift, done, busy, finish, data_in}, '0);
        reset = 1'b1;
        abort = 1'b0;
        check("pre_edge ready", 32'(start_ready), 32'd0);
        @(posedge clk);
        #1;
        check("first_edge ready", 32'(start_ready), 32'd1);
        check("first_edge pulses", {load, shift, done, busy}, 4'b0000);
        @(negedge clk);
        start_valid = 1'b0;

        // Abort while idle must not start anything.
        abort = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_abort state", {start_ready, busy, load, shift, done, finish}, 6'b100000);
        abort = 1'b0;

        foreach (vecs[i])
            run_transfer(vecs[i].word, vecs[i].n, vecs[i].abort_at,
                         vecs[i].exp_shifts, vecs[i].exp_ready, $sformatf("vec%0d", i));

        // Back-to-back with start_valid held high.
        wait_ready("b2b");
        word_in     = 8'hA5;
        n_shifts    = 4'd2;
        start_valid = 1'b1;
        @(negedge clk);
        word_in = 8'h3C;
        for (int c = 0; c < 6; c++) begin
            d[c]   = data_in;
            ld[c]  = load;
            rdy[c] = start_ready;
            @(negedge clk);
        end
        start_valid = 1'b0;
        check("b2b first data",   32'(d[0]),   32'hA5);
        check("b2b first load",   32'(ld[0]),  32'd1);
        check("b2b done not rdy", 32'(rdy[3]), 32'd0);
        check("b2b idle rdy",     32'(rdy[4]), 32'd1);
        check("b2b idle data",    32'(d[4]),   32'hA5);
        check("b2b idle no load", 32'(ld[4]),  32'd0);
        check("b2b second load",  32'(ld[5]),  32'd1);
        check("b2b second data",  32'(d[5]),   32'h3C);
        wait_ready("b2b end");

        // Reset dropped in the middle of the shift phase.
        word_in     = 8'h77;
        n_shifts    = 4'd8;
        start_valid = 1'b1;
        @(negedge clk);
        start_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid shifting", 32'(shift), 32'd1);
        reset = 1'b0;
        #1;
        check("mid reset outputs", {start_ready, load, shift, done, busy, finish, data_in}, '0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            seen += int'(finish) + int'(done);
        end
        check("mid no finish", 32'(seen), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid release ready", 32'(start_ready), 32'd1);
        check("mid release busy",  32'(busy),        32'd0);
        @(negedge clk);
        run_transfer(8'h77, 4'd4, -1, 4, 6, "post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
